sm4_key_schedule: RTL and testbench
===================================

# sm4_key_schedule

Iterative SM4 key-expansion controller. Accepts a 128-bit master key and produces the 32 round keys rk[0..31], one every two cycles. Feeds the registered S-box stage `tao_tranform_key` (instantiated inside) with K[i+1]^K[i+2]^K[i+3]^CK[i] and consumes its output through the key linear transform L'. Round keys stream to the round-key store used by the encrypt/decrypt datapath.

## Interface
- BYTE_WIDTH, 8, byte width; passed to the tao stage.
- WORD_WIDTH, 32, word width; passed to the tao stage.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low; also drives the tao stage rst_n.
- key_in  in  128  master key MK = {MK0,MK1,MK2,MK3}, MK0 in the MSBs; sampled only on acceptance.
- key_valid  in  1  master key present.
- key_ready  out  1  high only in IDLE.
- rk_valid  out  1  one-cycle pulse per round key.
- rk_index  out  5  index i of rk_data.
- rk_data  out  32  round key rk[i].
- busy  out  1  high in ISSUE and UPDATE.
- done  out  1  one-cycle pulse, coincident with the rk[31] rk_valid.

## Operation
- Constants: FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC. CK[i] byte j (j=0 is MSB) = ((4i+j)*7) mod 256, computed by table or arithmetic. Example: CK[0]=00070E15, CK[31]=646B7279.
- State registers: K0..K3 (4x32 shift window), round counter rnd[4:0], FSM {IDLE, ISSUE, UPDATE}.
- IDLE: key_ready=1. On key_valid&&key_ready: Kj <= MKj ^ FKj, rnd <= 0, go to ISSUE.
- ISSUE: tao input = K1^K2^K3^CK[rnd]. The tao stage registers S-box(x) at this edge. Go to UPDATE.
- UPDATE: B = tao data_out; T' = B ^ (B<<<13) ^ (B<<<23); rk = K0 ^ T'. At the edge: rk_data <= rk, rk_index <= rnd, rk_valid <= 1, shift {K0,K1,K2,K3} <= {K1,K2,K3,rk}.
  - If rnd==31: done <= 1, go to IDLE.
  - Otherwise rnd <= rnd+1, go to ISSUE.
- All rotations are 32-bit circular left. All XORs are full-width. rnd does not wrap within a run.
- No backpressure: the consumer must accept every rk_valid pulse. rk_index lets a decrypt consumer store keys in reverse order.
- key_valid while busy is ignored, since key_ready=0. The key is not latched.
- rk_data and rk_index hold their last value between pulses.

## Timing
- Reset (rst_n=0 at an edge): FSM=IDLE, rnd=0, K0..K3=0, rk_valid=0, done=0, rk_data=0, rk_index=0, busy=0, key_ready=1 after the edge. The tao output also clears.
- Reset mid-run aborts immediately. No further rk_valid pulses occur, and a new key is accepted normally afterwards.
- Edge 0 is the acceptance edge. rk[i] is registered at edge 2i+2, so rk_valid is high in the cycle after that edge.
- rk[0] appears after edge 2. rk[31] and done appear after edge 64. key_ready returns high in the same cycle as done.
- A new key can be accepted in the done cycle, giving back-to-back runs of 64 cycles each.
- busy is high from the cycle after edge 0 through the cycle after edge 63.
- rk_valid is never high on two consecutive cycles.

## Test plan
- Standard vector: MK=0123456789ABCDEFFEDCBA9876543210 -> rk[0]=F12186F9, rk[1]=41662B61, rk[31]=9124A012. rk_valid pulses exactly 32 times with rk_index 0..31 in order, and done occurs with index 31 at cycle 64 after acceptance.
- All-zero MK -> 32 keys match the software model. Check that rk[i] uses CK[i] by comparing every key against the model.
- Back-to-back: assert key_valid continuously with a new key presented in the done cycle -> second run is accepted there, and its rk[0] appears 2 cycles later with no gap errors.
- key_valid toggled with a different key mid-run -> outputs are unaffected, and exactly 32 keys match the first key.
- rst_n asserted at the cycle after edge 20 -> all outputs are 0 and key_ready=1 the cycle after that edge. A new standard-vector run then yields correct rk[0]=F12186F9.
- Idle hold: key_valid=0 for 100 cycles after reset -> rk_valid, done and busy stay 0, and key_ready stays 1.

Source files
------------

// File: rtl/sm4_key_schedule.sv
// SM4 key expansion: master key in, 32 round keys out, one every two cycles.
// Latency: rk[0] two edges after acceptance, rk[31] and done 64 edges after; no backpressure on rk_valid.
module tao_tranform_key #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);
  // Registered byte-wise S-box substitution; one cycle latency, always accepts.
  localparam int NB = WORD_WIDTH / BYTE_WIDTH;
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry x sits at bit 2047-8x, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  logic [WORD_WIDTH-1:0] sub;

  always_comb begin
    sub = '0;
    for (int b = 0; b < NB; b++)
      sub[b*BYTE_WIDTH +: BYTE_WIDTH] = BYTE_WIDTH'(sbox(8'(data_in[b*BYTE_WIDTH +: BYTE_WIDTH])));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_out <= '0;
    else        data_out <= sub;
  end
endmodule

// SM4 key schedule controller around the registered tao stage.
// Latency: 2 cycles per round key, 64 cycles per master key; consumer must take every rk_valid.
// Backpressure: none downstream; key_ready low while a run is in progress.
module sm4_key_schedule #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         rk_valid,
  output logic [4:0]   rk_index,
  output logic [31:0]  rk_data,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, ISSUE, UPDATE} state_t;
  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
  } kwin_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t      state, state_nxt;
  kwin_t       kw;
  logic [4:0]  rnd;
  logic [31:0] ck, tao_in, tao_out, t_lin, rk;
  logic [7:0]  ck_base;

  // CK byte j of round i is ((4i+j)*7) mod 256; 8-bit arithmetic gives the mod for free.
  always_comb begin
    ck      = '0;
    ck_base = {1'b0, rnd, 2'b00};
    for (int j = 0; j < 4; j++)
      ck[31-8*j -: 8] = (ck_base + 8'(j)) * 8'd7;
  end

  assign tao_in = kw.k1 ^ kw.k2 ^ kw.k3 ^ ck;
  assign t_lin  = tao_out ^ {tao_out[18:0], tao_out[31:19]} ^ {tao_out[8:0], tao_out[31:9]};
  assign rk     = kw.k0 ^ t_lin;

  tao_tranform_key #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_tao (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (tao_in),
    .data_out(tao_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = UPDATE;
      UPDATE:  state_nxt = (rnd == 5'd31) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kw       <= '0;
      rnd      <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE && key_valid) begin
        kw  <= key_in ^ FK;
        rnd <= '0;
      end else if (state == UPDATE) begin
        rk_data  <= rk;
        rk_index <= rnd;
        rk_valid <= 1'b1;
        kw       <= {kw.k1, kw.k2, kw.k3, rk};
        if (rnd == 5'd31) done <= 1'b1;
        else              rnd  <= rnd + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_sm4_key_schedule.sv
// Randomized bench for sm4_key_schedule against a word-level SM4 key expansion model.
module tb_sm4_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, rk_valid, busy, done;
  logic [4:0]   rk_index;
  logic [31:0]  rk_data;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [2047:0] SBOX_BITS = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [31:0] exp_rk [32];
  logic [31:0] got_rk [32];

  sm4_key_schedule #(.BYTE_WIDTH(8), .WORD_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .rk_valid (rk_valid),
    .rk_index (rk_index),
    .rk_data  (rk_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    int p;
    p = 2047 - 8 * int'(x);
    return SBOX_BITS[p -: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Straight from the SM4 definition: K[i+4] = K[i] ^ L'(tau(K[i+1]^K[i+2]^K[i+3]^CK[i])).
  task automatic model(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck, x, b;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      exp_rk[i] = k[i+4];
    end
  endtask

  // Caller has key_in/key_valid set up so the next rising edge is the acceptance edge.
  task automatic run_key(input logic [127:0] mk, input bit noise, input bit chain,
                         input logic [127:0] next_mk, input string tag);
    model(mk);
    @(posedge clk);
    for (int e = 0; e <= 64; e++) begin
      @(negedge clk);
      check({tag, ":busy"},  busy,      e <= 63);
      check({tag, ":ready"}, key_ready, e == 64);
      check({tag, ":done"},  done,      e == 64);
      check({tag, ":vld"},   rk_valid,  e >= 2 && e % 2 == 0);
      if (e >= 2 && e % 2 == 0) begin
        check({tag, ":idx"}, rk_index, e / 2 - 1);
        check({tag, ":rk"},  rk_data,  exp_rk[e/2-1]);
        got_rk[e/2-1] = rk_data;
      end else if (e >= 3) begin
        check({tag, ":hold"}, rk_data, exp_rk[(e-1)/2-1]);
      end
      if (noise && e >= 1 && e <= 40) begin
        key_valid = 1'($urandom % 2);
        key_in    = {$urandom, $urandom, $urandom, $urandom};
      end else if (e == 64 && chain) begin
        key_in    = next_mk;
        key_valid = 1'b1;
      end else begin
        key_valid = 1'b0;
      end
      if (e < 64) @(posedge clk);
    end
  endtask

  initial begin
    logic [127:0] ka, kb;
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", {rk_valid, done, busy, rk_index, rk_data}, '0);
    check("rst_ready", key_ready, 1'b1);
    rst_n = 1'b1;

    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("idle", {rk_valid, done, busy, key_ready}, 4'b0001);
    end

    key_in = STD_KEY; key_valid = 1'b1;
    run_key(STD_KEY, 1'b0, 1'b0, '0, "std");
    check("std_rk0",  got_rk[0],  32'hF12186F9);
    check("std_rk1",  got_rk[1],  32'h41662B61);
    check("std_rk31", got_rk[31], 32'h9124A012);

    @(negedge clk); key_in = '0; key_valid = 1'b1;
    run_key('0, 1'b0, 1'b0, '0, "zero");

    ka = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); key_in = ka; key_valid = 1'b1;
    run_key(ka, 1'b1, 1'b0, '0, "noise");

    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); key_in = STD_KEY; key_valid = 1'b1;
    run_key(STD_KEY, 1'b0, 1'b1, ka, "b2b0");
    run_key(ka, 1'b0, 1'b1, kb, "b2b1");
    run_key(kb, 1'b0, 1'b0, '0, "b2b2");

    // Abort a run with reset in the cycle after edge 20.
    @(negedge clk); key_in = STD_KEY; key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); key_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("abort_out", {rk_valid, done, busy, rk_index, rk_data}, '0);
    check("abort_ready", key_ready, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_abort", {rk_valid, done, busy}, 3'b000);
    end
    key_in = STD_KEY; key_valid = 1'b1;
    run_key(STD_KEY, 1'b0, 1'b0, '0, "rerun");
    check("rerun_rk0", got_rk[0], 32'hF12186F9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
